// File: rtl/pipeline_shell.sv
// pipeline_shell: buffers DUT RVFI retirements, steps the ISS once per retirement and
// re-emits each ISS result as an ordered RVFI retirement. Optional macro: PIPELINE_SHELL_MISMATCH_CHECK_EN.
module pipeline_shell #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ILEN       = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            rvfi_valid_i,
   input  logic [XLEN-1:0] rvfi_pc_rdata_i,
   input  logic [ILEN-1:0] rvfi_insn_i,
   input  logic            rvfi_intr_i,
   input  logic            rvfi_halt_i,
   output logic            step_valid_o,
   input  logic            step_ready_i,
   output logic            step_intr_o,
   input  logic            iss_valid_i,
   input  logic [XLEN-1:0] iss_pc_i,
   input  logic [ILEN-1:0] iss_insn_i,
   input  logic            iss_trap_i,
   input  logic [4:0]      iss_rd_addr_i,
   input  logic [XLEN-1:0] iss_rd_wdata_i,
   output logic            rvfi_valid_o,
   output logic [63:0]     rvfi_order_o,
   output logic [XLEN-1:0] rvfi_pc_rdata_o,
   output logic [ILEN-1:0] rvfi_insn_o,
   output logic            rvfi_trap_o,
   output logic            rvfi_intr_o,
   output logic            rvfi_halt_o,
   output logic [4:0]      rvfi_rd_addr_o,
   output logic [XLEN-1:0] rvfi_rd_wdata_o,
   output logic            overflow_o,
   output logic            mismatch_o
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] insn;
      logic            intr;
      logic            halt;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   entry_t         r_mem [FIFO_DEPTH];
   logic [PTR_W:0] r_wptr, r_rptr;
   entry_t         r_hold;
   state_t         r_state, w_state_nxt;
   logic           r_halted;
   logic           r_overflow;
   logic           r_step_valid, r_step_intr;

   logic            r_out_valid;
   logic [63:0]     r_order_cnt, r_out_order;
   logic [XLEN-1:0] r_out_pc, r_out_wdata;
   logic [ILEN-1:0] r_out_insn;
   logic            r_out_trap, r_out_intr, r_out_halt;
   logic [4:0]      r_out_rd;

   logic   w_empty, w_full, w_pop, w_push_req, w_push, w_drop, w_iss_done;
   entry_t w_head, w_in;

   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
   assign w_head     = r_mem[r_rptr[PTR_W-1:0]];
   assign w_pop      = (r_state == REQ) && step_ready_i;
   // After halt retires, further DUT retirements are silently discarded
   assign w_push_req = rvfi_valid_i && !r_halted;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;
   assign w_iss_done = (r_state == WAIT) && iss_valid_i;
   assign w_in       = '{pc: rvfi_pc_rdata_i, insn: rvfi_insn_i,
                         intr: rvfi_intr_i, halt: rvfi_halt_i};

   // Retirement buffer storage (no reset needed; pointers define validity)
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= w_in;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
         r_hold     <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
         if (w_pop) begin
            r_rptr <= r_rptr + (PTR_W+1)'(1);
            r_hold <= w_head;
         end
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Step FSM state register plus registered step request outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_step_valid <= 1'b0;
         r_step_intr  <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_step_valid <= (w_state_nxt == REQ);
         r_step_intr  <= (w_state_nxt == REQ) && w_head.intr;
         if (w_iss_done && r_hold.halt) r_halted <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (!w_empty && !r_halted) w_state_nxt = REQ;
         REQ:     if (step_ready_i)          w_state_nxt = WAIT;
         WAIT:    if (iss_valid_i)           w_state_nxt = IDLE;
         default:                            w_state_nxt = IDLE;
      endcase
   end

   // Reference retirement output register; data fields hold between pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_out_valid <= 1'b0;
         r_order_cnt <= '0;
         r_out_order <= '0;
         r_out_pc    <= '0;
         r_out_insn  <= '0;
         r_out_trap  <= 1'b0;
         r_out_intr  <= 1'b0;
         r_out_halt  <= 1'b0;
         r_out_rd    <= '0;
         r_out_wdata <= '0;
      end else begin
         r_out_valid <= w_iss_done;
         if (w_iss_done) begin
            r_out_order <= r_order_cnt;
            r_order_cnt <= r_order_cnt + 64'd1;
            r_out_pc    <= iss_pc_i;
            r_out_insn  <= iss_insn_i;
            r_out_trap  <= iss_trap_i;
            r_out_intr  <= r_hold.intr;
            r_out_halt  <= r_hold.halt;
            r_out_rd    <= iss_rd_addr_i;
            r_out_wdata <= iss_rd_wdata_i;
         end
      end
   end

`ifdef PIPELINE_SHELL_MISMATCH_CHECK_EN
   logic r_mismatch;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_mismatch <= 1'b0;
      else       r_mismatch <= w_iss_done &&
                               ((iss_pc_i != r_hold.pc) || (iss_insn_i != r_hold.insn));
   end
   assign mismatch_o = r_mismatch;
`else
   logic w_unused_hold;
   assign w_unused_hold = ^{r_hold.pc, r_hold.insn};
   assign mismatch_o    = 1'b0;
`endif

   assign step_valid_o    = r_step_valid;
   assign step_intr_o     = r_step_intr;
   assign overflow_o      = r_overflow;
   assign rvfi_valid_o    = r_out_valid;
   assign rvfi_order_o    = r_out_order;
   assign rvfi_pc_rdata_o = r_out_pc;
   assign rvfi_insn_o     = r_out_insn;
   assign rvfi_trap_o     = r_out_trap;
   assign rvfi_intr_o     = r_out_intr;
   assign rvfi_halt_o     = r_out_halt;
   assign rvfi_rd_addr_o  = r_out_rd;
   assign rvfi_rd_wdata_o = r_out_wdata;

endmodule

// File: tb/tb_pipeline_shell.sv
// Directed self-checking bench for pipeline_shell with a queued ISS responder model.
`timescale 1ns/1ps
module tb_pipeline_shell;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rvfi_valid_i, rvfi_intr_i, rvfi_halt_i;
   logic [31:0] rvfi_pc_rdata_i, rvfi_insn_i;
   logic        step_valid_o, step_ready_i, step_intr_o;
   logic        iss_valid_i, iss_trap_i;
   logic [31:0] iss_pc_i, iss_insn_i, iss_rd_wdata_i;
   logic [4:0]  iss_rd_addr_i;
   logic        rvfi_valid_o, rvfi_trap_o, rvfi_intr_o, rvfi_halt_o;
   logic [63:0] rvfi_order_o;
   logic [31:0] rvfi_pc_rdata_o, rvfi_insn_o, rvfi_rd_wdata_o;
   logic [4:0]  rvfi_rd_addr_o;
   logic        overflow_o, mismatch_o;

   typedef struct {
      logic [31:0] pc; logic [31:0] insn; logic trap; logic [4:0] rd; logic [31:0] wd;
   } rsp_t;
   typedef struct {
      logic [31:0] pc; logic [31:0] insn; logic [63:0] order;
      logic trap; logic intr; logic halt; logic mm; logic [4:0] rd; logic [31:0] wd; int cyc;
   } out_t;

   rsp_t rsp_q[$];
   out_t out_q[$];
   out_t mon_o;
   rsp_t cur;
   int   iss_lat = 1;
   int   cyc = 0;
   int   stray = 0;
   int   errors = 0;
   int   checks = 0;

   pipeline_shell dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
      .rvfi_intr_i(rvfi_intr_i), .rvfi_halt_i(rvfi_halt_i),
      .step_valid_o(step_valid_o), .step_ready_i(step_ready_i), .step_intr_o(step_intr_o),
      .iss_valid_i(iss_valid_i), .iss_pc_i(iss_pc_i), .iss_insn_i(iss_insn_i),
      .iss_trap_i(iss_trap_i), .iss_rd_addr_i(iss_rd_addr_i), .iss_rd_wdata_i(iss_rd_wdata_i),
      .rvfi_valid_o(rvfi_valid_o), .rvfi_order_o(rvfi_order_o), .rvfi_pc_rdata_o(rvfi_pc_rdata_o),
      .rvfi_insn_o(rvfi_insn_o), .rvfi_trap_o(rvfi_trap_o), .rvfi_intr_o(rvfi_intr_o),
      .rvfi_halt_o(rvfi_halt_o), .rvfi_rd_addr_o(rvfi_rd_addr_o), .rvfi_rd_wdata_o(rvfi_rd_wdata_o),
      .overflow_o(overflow_o), .mismatch_o(mismatch_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge
   always @(negedge clk_i) begin
      if (rvfi_valid_o) begin
         mon_o.pc = rvfi_pc_rdata_o; mon_o.insn = rvfi_insn_o; mon_o.order = rvfi_order_o;
         mon_o.trap = rvfi_trap_o; mon_o.intr = rvfi_intr_o; mon_o.halt = rvfi_halt_o;
         mon_o.mm = mismatch_o; mon_o.rd = rvfi_rd_addr_o; mon_o.wd = rvfi_rd_wdata_o;
         mon_o.cyc = cyc;
         out_q.push_back(mon_o);
      end else if (mismatch_o) begin
         stray++;
      end
   end

   // ISS model: answers each accepted step iss_lat cycles later with the next queued result
   initial begin
      iss_valid_i = 0; iss_pc_i = 0; iss_insn_i = 0; iss_trap_i = 0;
      iss_rd_addr_i = 0; iss_rd_wdata_i = 0;
      forever begin
         @(posedge clk_i);
         if (step_valid_o && step_ready_i && !rst_i && rsp_q.size() > 0) begin
            cur = rsp_q.pop_front();
            repeat (iss_lat) @(negedge clk_i);
            iss_pc_i = cur.pc; iss_insn_i = cur.insn; iss_trap_i = cur.trap;
            iss_rd_addr_i = cur.rd; iss_rd_wdata_i = cur.wd; iss_valid_i = 1;
            @(negedge clk_i);
            iss_valid_i = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic retire(input logic [31:0] pc, input logic [31:0] insn,
                         input logic intr, input logic halt);
      rvfi_valid_i = 1; rvfi_pc_rdata_i = pc; rvfi_insn_i = insn;
      rvfi_intr_i = intr; rvfi_halt_i = halt;
      @(negedge clk_i);
      rvfi_valid_i = 0;
   endtask

   task automatic wait_out(input int n);
      int k = 0;
      while (out_q.size() < n && k < 300) begin @(negedge clk_i); k++; end
      repeat (8) @(negedge clk_i);
   endtask

   task automatic reset_dut();
      rst_i = 1; step_ready_i = 0; rvfi_valid_i = 0;
      repeat (2) @(negedge clk_i);
      rst_i = 0;
      rsp_q.delete(); out_q.delete(); stray = 0; iss_lat = 1;
      @(negedge clk_i);
   endtask

   task automatic push_rsp(input logic [31:0] pc, input logic [31:0] insn,
                           input logic [4:0] rd, input logic [31:0] wd);
      rsp_t r;
      r.pc = pc; r.insn = insn; r.trap = 0; r.rd = rd; r.wd = wd;
      rsp_q.push_back(r);
   endtask

   task automatic test_reset();
      rst_i = 1; step_ready_i = 0; rvfi_valid_i = 0; rvfi_intr_i = 0; rvfi_halt_i = 0;
      rvfi_pc_rdata_i = 0; rvfi_insn_i = 0;
      repeat (3) @(negedge clk_i);
      checks++; if (rvfi_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rvfi_valid_o); end
      checks++; if (rvfi_order_o !== 64'd0) begin errors++; $display("FAIL reset_order got=%0d exp=0", rvfi_order_o); end
      checks++; if ({rvfi_pc_rdata_o, rvfi_insn_o, rvfi_rd_wdata_o, rvfi_rd_addr_o, rvfi_trap_o, rvfi_intr_o, rvfi_halt_o} !== '0) begin
         errors++; $display("FAIL reset_fields got pc=%h insn=%h exp all 0", rvfi_pc_rdata_o, rvfi_insn_o); end
      checks++; if ({step_valid_o, step_intr_o, overflow_o, mismatch_o} !== 4'b0) begin
         errors++; $display("FAIL reset_flags got=%b exp=0000", {step_valid_o, step_intr_o, overflow_o, mismatch_o}); end
      rst_i = 0;
      repeat (3) @(negedge clk_i);
      checks++; if (step_valid_o !== 1'b0) begin errors++; $display("FAIL idle_empty step_valid got=%b exp=0", step_valid_o); end
   endtask

   task automatic test_single();
      int t0;
      reset_dut();
      step_ready_i = 1;
      push_rsp(32'h8000_0000, 32'h0000_0013, 5'd0, 32'd0);
      t0 = cyc;
      retire(32'h8000_0000, 32'h0000_0013, 0, 0);
      wait_out(1);
      checks++; if (out_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", out_q.size()); end
      if (out_q.size() == 1) begin
         checks++; if (out_q[0].order !== 64'd0) begin errors++; $display("FAIL single_order got=%0d exp=0", out_q[0].order); end
         checks++; if (out_q[0].pc !== 32'h8000_0000) begin errors++; $display("FAIL single_pc got=%h exp=80000000", out_q[0].pc); end
         checks++; if (out_q[0].insn !== 32'h13) begin errors++; $display("FAIL single_insn got=%h exp=00000013", out_q[0].insn); end
         checks++; if (out_q[0].mm !== 1'b0) begin errors++; $display("FAIL single_mismatch got=%b exp=0", out_q[0].mm); end
         checks++; if (out_q[0].cyc - t0 - 1 != 3) begin errors++; $display("FAIL single_latency got=%0d exp=3", out_q[0].cyc - t0 - 1); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] intr_pat;
      reset_dut();
      intr_pat = 4'b1001;
      step_ready_i = 1; iss_lat = 3;
      for (int i = 0; i < 4; i++) push_rsp(32'h1000 + 32'(i*4), 32'h0010_0093, 5'(i+1), 32'hA0 + 32'(i));
      for (int i = 0; i < 4; i++) retire(32'h1000 + 32'(i*4), 32'h0010_0093, intr_pat[i], 0);
      wait_out(4);
      checks++; if (out_q.size() != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", out_q.size()); end
      if (out_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_q[i].order !== 64'(i) || out_q[i].pc !== 32'h1000 + 32'(i*4) || out_q[i].intr !== intr_pat[i] ||
                out_q[i].rd !== 5'(i+1) || out_q[i].wd !== 32'hA0 + 32'(i)) begin
               errors++;
               $display("FAIL b2b_entry%0d got order=%0d pc=%h intr=%b rd=%0d wd=%h exp order=%0d pc=%h intr=%b rd=%0d wd=%h",
                        i, out_q[i].order, out_q[i].pc, out_q[i].intr, out_q[i].rd, out_q[i].wd,
                        i, 32'h1000 + 32'(i*4), intr_pat[i], i+1, 32'hA0 + 32'(i));
            end
         end
      end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_overflow got=%b exp=0", overflow_o); end
   endtask

   task automatic test_overflow();
      reset_dut();
      for (int i = 0; i < 4; i++) retire(32'h2000 + 32'(i*4), 32'h13, 0, 0);
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_at_full got=%b exp=0", overflow_o); end
      for (int i = 4; i < 6; i++) retire(32'h2000 + 32'(i*4), 32'h13, 1, 0);
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
      for (int i = 0; i < 6; i++) push_rsp(32'h2000 + 32'(i*4), 32'h13, 5'd0, 32'd0);
      step_ready_i = 1;
      wait_out(4);
      checks++; if (out_q.size() != 4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", out_q.size()); end
      foreach (out_q[i]) begin
         checks++;
         if (out_q[i].intr !== 1'b0 || out_q[i].order !== 64'(i)) begin
            errors++; $display("FAIL ovf_entry%0d got intr=%b order=%0d exp intr=0 order=%0d", i, out_q[i].intr, out_q[i].order, i);
         end
      end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
   endtask

   task automatic test_full_push_pop();
      reset_dut();
      for (int i = 0; i < 4; i++) retire(32'h3000 + 32'(i*4), 32'h13, 0, 0);
      for (int i = 0; i < 5; i++) push_rsp(32'h3000 + 32'(i*4), 32'h13, 5'd0, 32'd0);
      step_ready_i = 1;
      retire(32'h3010, 32'h13, 1, 0);
      wait_out(5);
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got=%b exp=0", overflow_o); end
      checks++; if (out_q.size() != 5) begin errors++; $display("FAIL fullpp_count got=%0d exp=5", out_q.size()); end
      if (out_q.size() == 5) begin
         checks++;
         if (out_q[4].intr !== 1'b1 || out_q[4].order !== 64'd4) begin
            errors++; $display("FAIL fullpp_last got intr=%b order=%0d exp intr=1 order=4", out_q[4].intr, out_q[4].order);
         end
      end
   endtask

   task automatic test_interrupt();
      reset_dut();
      retire(32'h4000, 32'h13, 1, 0);
      retire(32'h4004, 32'h13, 0, 0);
      repeat (2) @(negedge clk_i);
      checks++; if ({step_valid_o, step_intr_o} !== 2'b11) begin
         errors++; $display("FAIL intr_req got valid,intr=%b exp=11", {step_valid_o, step_intr_o}); end
      push_rsp(32'h4000, 32'h13, 5'd1, 32'd1);
      push_rsp(32'h4004, 32'h13, 5'd2, 32'd2);
      step_ready_i = 1;
      wait_out(2);
      checks++; if (out_q.size() != 2) begin errors++; $display("FAIL intr_count got=%0d exp=2", out_q.size()); end
      if (out_q.size() == 2) begin
         checks++; if ({out_q[0].intr, out_q[1].intr} !== 2'b10) begin
            errors++; $display("FAIL intr_out got=%b exp=10", {out_q[0].intr, out_q[1].intr}); end
      end
   endtask

   task automatic test_mismatch();
      logic exp_mm;
`ifdef PIPELINE_SHELL_MISMATCH_CHECK_EN
      exp_mm = 1'b1;
`else
      exp_mm = 1'b0;
`endif
      reset_dut();
      step_ready_i = 1;
      push_rsp(32'h104, 32'h13, 5'd0, 32'd0);
      retire(32'h100, 32'h13, 0, 0);
      wait_out(1);
      push_rsp(32'h200, 32'h13, 5'd0, 32'd0);
      retire(32'h200, 32'h13, 0, 0);
      wait_out(2);
      checks++; if (out_q.size() != 2) begin errors++; $display("FAIL mm_count got=%0d exp=2", out_q.size()); end
      if (out_q.size() == 2) begin
         checks++; if (out_q[0].mm !== exp_mm) begin errors++; $display("FAIL mm_diff got=%b exp=%b", out_q[0].mm, exp_mm); end
         checks++; if (out_q[1].mm !== 1'b0) begin errors++; $display("FAIL mm_same got=%b exp=0", out_q[1].mm); end
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL mm_stray got=%0d exp=0", stray); end
   endtask

   task automatic test_reset_wait();
      reset_dut();
      step_ready_i = 1;
      retire(32'h500, 32'h13, 0, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1;
      @(negedge clk_i);
      rst_i = 0;
      repeat (6) @(negedge clk_i);
      checks++; if (out_q.size() != 0) begin errors++; $display("FAIL rstwait_abandon got=%0d outputs exp=0", out_q.size()); end
      push_rsp(32'h600, 32'h13, 5'd3, 32'h33);
      retire(32'h600, 32'h13, 0, 0);
      wait_out(1);
      checks++; if (out_q.size() != 1) begin errors++; $display("FAIL rstwait_count got=%0d exp=1", out_q.size()); end
      if (out_q.size() == 1) begin
         checks++; if (out_q[0].order !== 64'd0 || out_q[0].pc !== 32'h600) begin
            errors++; $display("FAIL rstwait_next got order=%0d pc=%h exp order=0 pc=600", out_q[0].order, out_q[0].pc); end
      end
   endtask

   task automatic test_halt();
      reset_dut();
      step_ready_i = 1;
      push_rsp(32'h700, 32'h13, 5'd0, 32'd0);
      retire(32'h700, 32'h13, 0, 1);
      wait_out(1);
      checks++; if (out_q.size() != 1) begin errors++; $display("FAIL halt_count got=%0d exp=1", out_q.size()); end
      if (out_q.size() == 1) begin
         checks++; if (out_q[0].halt !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", out_q[0].halt); end
      end
      push_rsp(32'h704, 32'h13, 5'd0, 32'd0);
      push_rsp(32'h708, 32'h13, 5'd0, 32'd0);
      for (int i = 0; i < 6; i++) retire(32'h704 + 32'(i*4), 32'h13, 0, 0);
      repeat (10) @(negedge clk_i);
      checks++; if (out_q.size() != 1) begin errors++; $display("FAIL halt_stay got=%0d outputs exp=1", out_q.size()); end
      checks++; if ({step_valid_o, overflow_o} !== 2'b00) begin
         errors++; $display("FAIL halt_flags got valid,ovf=%b exp=00", {step_valid_o, overflow_o}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_push_pop();
      test_interrupt();
      test_mismatch();
      test_reset_wait();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
